// File: rtl/divide_sequencer_pkg.sv
// Shared ALU constants and divide sequencer encodings.
package divide_sequencer_pkg;
  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;

  localparam logic [4:0]      OPDIV  = 5'b01100;
  localparam logic [4:0]      OPDIVU = 5'b01101;
  localparam logic [4:0]      OPREM  = 5'b01110;
  localparam logic [4:0]      OPREMU = 5'b01111;
  localparam logic [XLEN-1:0] ZERO   = '0;

  typedef enum logic [1:0] {
    DSTATE_IDLE = 2'd0,
    DSTATE_ITER = 2'd1,
    DSTATE_FIX  = 2'd2
  } dstate_e;

  // Two's-complement magnitude for signed ops; 0x80000000 stays 0x80000000 as unsigned.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? (ZERO - v) : v;
  endfunction
endpackage

// File: rtl/divide_step.sv
// One combinational radix-2 restoring divide step.
module divide_step
  import divide_sequencer_pkg::*;
(
  input  logic [XLEN:0]   rem_i,
  input  logic            dbit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic            qbit_o
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          unused_msb;

  // Remainder stays below the divisor, so its top bit never carries into the shift.
  assign unused_msb = rem_i[XLEN];
  assign shifted    = {rem_i[XLEN-1:0], dbit_i};
  assign diff       = shifted - {1'b0, divisor_i};
  assign qbit_o     = (shifted >= {1'b0, divisor_i});
  assign rem_o      = qbit_o ? diff : shifted;
endmodule

// File: rtl/divide_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer, one quotient bit per cycle.
// DIVIDE_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip the iterations.
module divide_sequencer
  import divide_sequencer_pkg::*;
(
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            iValid,
  input  logic [4:0]      iControl,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic            iFlush,
  output logic            oReady,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);
  dstate_e         state_q, state_d;
  logic [4:0]      cnt_q, cnt_d, op_q, op_d;
  logic [XLEN-1:0] dvd_q, dvd_d, dvs_q, dvs_d, spec_res_q, spec_res_d, res_q, res_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d, spec_q, spec_d, done_q, done_d;

  logic            in_signed, in_div, op_ok, accept, b_zero, ovf;
  logic [XLEN-1:0] spec_res_in, q_fix, r_fix, fix_res;
  logic [XLEN:0]   step_rem;
  logic            step_q;

  assign in_signed = (iControl == OPDIV) || (iControl == OPREM);
  assign in_div    = (iControl == OPDIV) || (iControl == OPDIVU);
  assign op_ok     = in_signed || (iControl == OPDIVU) || (iControl == OPREMU);
  assign accept    = iValid && oReady && !iFlush && op_ok;
  assign b_zero    = (iB == ZERO);
  assign ovf       = in_signed && (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);
  assign spec_res_in = b_zero ? (in_div ? 32'hFFFF_FFFF : iA)
                              : (in_div ? 32'h8000_0000 : ZERO);

  divide_step u_step (
    .rem_i    (rem_q),
    .dbit_i   (dvd_q[XLEN-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .qbit_o   (step_q)
  );

  // Dividend register doubles as the quotient: bits shift in at the LSB.
  assign q_fix   = qneg_q ? (ZERO - dvd_q) : dvd_q;
  assign r_fix   = rneg_q ? (ZERO - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
  assign fix_res = spec_q ? spec_res_q
                 : (((op_q == OPDIV) || (op_q == OPDIVU)) ? q_fix : r_fix);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    res_d      = res_q;
    done_d     = 1'b0;
    case (state_q)
      DSTATE_IDLE: if (accept) begin
        op_d       = iControl;
        dvd_d      = mag(iA, in_signed);
        dvs_d      = mag(iB, in_signed);
        qneg_d     = in_signed && (iA[XLEN-1] ^ iB[XLEN-1]);
        rneg_d     = in_signed && iA[XLEN-1];
        rem_d      = '0;
        spec_d     = b_zero || ovf;
        spec_res_d = spec_res_in;
        cnt_d      = 5'(DIV_ITERS - 1);
`ifdef DIVIDE_FAST_SPECIAL_EN
        state_d    = (b_zero || ovf) ? DSTATE_FIX : DSTATE_ITER;
`else
        state_d    = DSTATE_ITER;
`endif
      end
      DSTATE_ITER: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[XLEN-2:0], step_q};
        if (cnt_q == 5'd0) state_d = DSTATE_FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      DSTATE_FIX: begin
        res_d   = fix_res;
        done_d  = 1'b1;
        state_d = DSTATE_IDLE;
      end
      default: state_d = DSTATE_IDLE;
    endcase
    if (iFlush) begin
      state_d = DSTATE_IDLE;
      done_d  = 1'b0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q    <= DSTATE_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      res_q      <= res_d;
      done_q     <= done_d;
    end
  end

  assign oReady  = (state_q == DSTATE_IDLE);
  assign oBusy   = !oReady;
  assign oDone   = done_q;
  assign oResult = res_q;
endmodule

// File: tb/tb_divide_sequencer.sv
// Directed-vector bench for divide_sequencer.
module tb_divide_sequencer;
  import divide_sequencer_pkg::*;

`ifdef DIVIDE_FAST_SPECIAL_EN
  localparam int SPL = 2;
`else
  localparam int SPL = 34;
`endif

  logic        iCLK = 1'b0;
  logic        iRSTn, iValid, iFlush;
  logic [4:0]  iControl;
  logic [31:0] iA, iB;
  logic        oReady, oBusy, oDone;
  logic [31:0] oResult;
  int          n_chk = 0;
  int          n_fail = 0;

  divide_sequencer dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iValid(iValid), .iControl(iControl),
    .iA(iA), .iB(iB), .iFlush(iFlush),
    .oReady(oReady), .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; issues the request and waits for oDone.
  task automatic do_op(input string tag, input logic [4:0] ctl,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int n = 0;
    bit seen = 0;
    iValid = 1'b1; iControl = ctl; iA = a; iB = b;
    while (!seen && n < 100) begin
      @(negedge iCLK);
      n++;
      iValid = 1'b0; iA = $urandom; iB = $urandom;
      if (oDone) seen = 1;
    end
    chk({tag, " done"}, 32'(seen), 32'd1);
    chk({tag, " lat"}, 32'(n), 32'(lat));
    chk({tag, " res"}, oResult, exp);
    chk({tag, " ready"}, 32'(oReady), 32'd1);
  endtask

  initial begin
    int seen_done;
    iRSTn = 1'b0; iValid = 1'b0; iFlush = 1'b0; iControl = '0; iA = '0; iB = '0;
    repeat (2) @(negedge iCLK);
    chk("rst ready", 32'(oReady), 32'd1);
    chk("rst busy", 32'(oBusy), 32'd0);
    chk("rst done", 32'(oDone), 32'd0);
    chk("rst res", oResult, 32'd0);
    iRSTn = 1'b1;
    @(negedge iCLK);

    do_op("divu 100/7", OPDIVU, 32'd100, 32'd7, 32'd14, 34);
    @(negedge iCLK);
    chk("done pulse", 32'(oDone), 32'd0);
    chk("res hold", oResult, 32'd14);
    do_op("remu 100/7", OPREMU, 32'd100, 32'd7, 32'd2, 34);
    // The following ops are each issued in the previous op's oDone cycle.
    do_op("div -7/2", OPDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    do_op("rem -7/2", OPREM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    do_op("rem 7/-2", OPREM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    do_op("divu ffffffff/16", OPDIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 34);
    do_op("remu ffffffff/16", OPREMU, 32'hFFFF_FFFF, 32'd16, 32'hF, 34);
    do_op("div -100/-7", OPDIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 34);
    do_op("rem -100/-7", OPREM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34);
    do_op("div ovf", OPDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPL);
    do_op("rem ovf", OPREM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPL);
    do_op("divu 5/0", OPDIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPL);
    do_op("rem 5/0", OPREM, 32'd5, 32'd0, 32'd5, SPL);
    do_op("div -5/0", OPDIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPL);
    do_op("remu 0x80000000 by 0", OPREMU, 32'h8000_0000, 32'd0, 32'h8000_0000, SPL);
    @(negedge iCLK);

    // Unsupported op code is ignored.
    iValid = 1'b1; iControl = 5'd0; iA = 32'd8; iB = 32'd2;
    @(negedge iCLK);
    chk("bad op busy", 32'(oBusy), 32'd0);
    // Flush in IDLE blocks acceptance.
    iControl = OPDIVU; iFlush = 1'b1;
    @(negedge iCLK);
    chk("idle flush busy", 32'(oBusy), 32'd0);
    iValid = 1'b0; iFlush = 1'b0;

    // Flush in cycle 10 of an op.
    iValid = 1'b1; iControl = OPDIVU; iA = 32'd50; iB = 32'd5;
    @(negedge iCLK);
    iValid = 1'b0;
    repeat (9) @(negedge iCLK);
    chk("pre-flush busy", 32'(oBusy), 32'd1);
    iFlush = 1'b1;
    @(negedge iCLK);
    iFlush = 1'b0;
    chk("flush ready", 32'(oReady), 32'd1);
    chk("flush done", 32'(oDone), 32'd0);
    seen_done = 0;
    repeat (40) begin
      @(negedge iCLK);
      if (oDone) seen_done++;
    end
    chk("flush no done", 32'(seen_done), 32'd0);
    do_op("divu 9/3", OPDIVU, 32'd9, 32'd3, 32'd3, 34);
    @(negedge iCLK);

    // Flush during the FIX cycle.
    iValid = 1'b1; iControl = OPDIVU; iA = 32'd20; iB = 32'd4;
    @(negedge iCLK);
    iValid = 1'b0;
    repeat (32) @(negedge iCLK);
    iFlush = 1'b1;
    @(negedge iCLK);
    iFlush = 1'b0;
    chk("fix flush done", 32'(oDone), 32'd0);
    chk("fix flush res", oResult, 32'd3);
    chk("fix flush ready", 32'(oReady), 32'd1);
    @(negedge iCLK);

    // Asynchronous reset mid-ITER.
    iValid = 1'b1; iControl = OPDIVU; iA = 32'd100; iB = 32'd7;
    @(negedge iCLK);
    iValid = 1'b0;
    repeat (5) @(negedge iCLK);
    iRSTn = 1'b0;
    #1;
    chk("arst ready", 32'(oReady), 32'd1);
    chk("arst busy", 32'(oBusy), 32'd0);
    chk("arst done", 32'(oDone), 32'd0);
    chk("arst res", oResult, 32'd0);
    @(negedge iCLK);
    iRSTn = 1'b1;
    @(negedge iCLK);
    do_op("post-reset divu 9/3", OPDIVU, 32'd9, 32'd3, 32'd3, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/divide_sequencer.md
# divide_sequencer

Multi-cycle sequencer for the M-extension divide and remainder operations (OPDIV, OPDIVU, OPREM, OPREMU). It replaces the single-cycle combinational divide path of the ALU with a radix-2 restoring engine that produces one quotient bit per cycle. It sits beside the ALU in the execute stage and uses a valid/ready handshake. The core stalls while oBusy is high and captures oResult on oDone.

## Interface
- XLEN, 32, operand and result width; only 32 is supported.
- iCLK  in  1  core clock; all state updates on the rising edge.
- iRSTn  in  1  asynchronous, active-low reset.
- iValid  in  1  request strobe; accepted when iValid & oReady.
- iControl  in  5  ALU operation code, one of OPDIV/OPDIVU/OPREM/OPREMU from the shared constants.
- iA  in  XLEN  dividend.
- iB  in  XLEN  divisor.
- iFlush  in  1  abort any operation in flight (pipeline flush).
- oReady  out  1  high in IDLE only.
- oBusy  out  1  high in every state other than IDLE.
- oDone  out  1  one-cycle pulse; oResult is valid in that cycle.
- oResult  out  XLEN  quotient or remainder; holds its value until the next oDone.

## Operation
- States and transitions:
  - IDLE: accept a request -> ITER.
  - ITER: 32 cycles, counter 31 down to 0 -> FIX.
  - FIX: 1 cycle -> IDLE, with oDone asserted.
- Acceptance:
  - Latch the op.
  - Latch the operand magnitudes: for signed ops (OPDIV/OPREM), |iA| and |iB|; for unsigned ops, the raw values.
  - Latch qneg = A[31]^B[31] (signed ops only) and rneg = A[31] (signed ops only).
  - Clear the 33-bit partial remainder.
- Requests with any other iControl are not accepted: no state change and no oDone.
- ITER step:
  - rem = {rem[31:0], dividend[31]}.
  - Shift the dividend left.
  - If rem >= divisor: rem -= divisor and the quotient bit is 1; otherwise the quotient bit is 0.
  - The magnitude of -2^31 (0x80000000) is handled as unsigned 32-bit.
- FIX:
  - OPDIV/OPDIVU: select the quotient, negated if qneg.
  - OPREM/OPREMU: select the remainder, negated if rneg.
  - Register the selection into oResult and pulse oDone.
- Special cases. Results must match RISC-V exactly regardless of configuration:
  - Divide by zero: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = iA.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- iFlush:
  - In any state, the next edge returns the block to IDLE with no oDone.
  - A flush in the FIX cycle suppresses oDone; oResult keeps its previous value.
  - iFlush in IDLE blocks acceptance in that cycle.
- Reset (including mid-operation):
  - State = IDLE, oReady = 1, oBusy = 0, oDone = 0, oResult = 0, counter = 0.

## Timing
- Accepting edge E0.
- ITER occupies the cycles after edges E0..E31.
- FIX occupies the cycle after E32.
- oDone is high in the cycle after edge E33, which is also the first cycle with oReady = 1.
- Fixed latency: 34 cycles from accept to oDone without the fast path.
- Back-to-back: a new request can be accepted in the same cycle oDone is high.
- The next op completes 34 cycles later.
- Operands need only be stable in the accepting cycle.

## Configuration
- DIVIDE_FAST_SPECIAL_EN:
  - Defined: on acceptance, divide-by-zero and signed overflow go directly to FIX with a precomputed result. oDone is high in the cycle after E1 (latency 2).
  - Undefined: these cases run the full 34-cycle sequence, and FIX substitutes the special result.
  - Result values are identical either way; only latency differs.

## Structure
- The op codes (OPDIV, OPDIVU, OPREM, OPREMU) and ZERO stay in the shared config constants used by the ALU.
- Add the state encodings DSTATE_IDLE, DSTATE_ITER and DSTATE_FIX, plus DIV_ITERS = 32, to the same shared file.
- One sub-module: divide_step, a combinational single restoring step (rem, dividend bit, divisor -> next rem, quotient bit).
- All registers, the FSM and the sign fix-up live in divide_sequencer.

## Test plan
- OPDIVU 100 / 7 -> oResult = 14 at exactly 34 cycles; OPREMU 100 / 7 -> 2.
- OPDIV -7 / 2 -> 0xFFFFFFFD (-3); OPREM -7 / 2 -> 0xFFFFFFFF (-1); OPREM 7 / -2 -> 1.
- OPDIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; OPREM -> 0.
  - Latency is 2 with DIVIDE_FAST_SPECIAL_EN and 34 without.
- OPDIVU 5 / 0 -> 0xFFFFFFFF; OPREM 5 / 0 -> 5.
  - Same latency split as above.
- Flush at cycle 10 of an op -> no oDone, oReady = 1 next cycle.
  - Then a new OPDIVU 9 / 3 -> 3 after 34 cycles.
- Assert iRSTn low mid-ITER -> all outputs at reset values immediately.
- Back-to-back requests in the oDone cycle -> two correct results 34 cycles apart.
